disp_timing_gen: RTL
====================

# disp_timing_gen

Display scan-out controller that sits directly downstream of the frame buffer's read port. It generates raster timing with hsync, vsync and data-enable. It issues one frame-buffer read strobe per active pixel and aligns the returned 24-bit RGB data with the sync outputs, so the panel or serializer can take the outputs directly. Single clock domain, identical to the frame buffer's read clock.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in clocks
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch in lines
- SYNC_POL, 0, sync active level (0 = active-low)
- RD_LAT, 1, frame-buffer read latency in clocks from sampled read strobe to valid data (1..4)

Ports:
- clk  in  1  pixel clock, same as the frame buffer read clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  scan enable
- rd_en_out  out  1  read strobe to the frame buffer rd_en_in
- data_in  in  24  pixel from the frame buffer data_out
- pix_out  out  24  aligned pixel, zero when de_out=0
- de_out  out  1  data enable
- hsync_out  out  1  horizontal sync
- vsync_out  out  1  vertical sync
- frame_start  out  1  one-clock pulse coincident with first active pixel of each frame

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is formed the same way from the V_ parameters.
- Counters: h_cnt is 0..H_TOTAL-1 and v_cnt is 0..V_TOTAL-1, both unsigned.
  - Width of each counter is $clog2 of its total.
  - h_cnt wraps to 0 after H_TOTAL-1; v_cnt increments on each h_cnt wrap.
  - v_cnt wraps to 0 after V_TOTAL-1.
- Region order within a line and within a frame: active, front porch, sync, back porch.
- Horizontal sync region: H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
- Vertical sync region uses the same form on v_cnt, with whole lines.
- FSM states:
  - IDLE: counters held at 0, sampled en=1 → RUN.
  - RUN: counters advance every clock.
  - RUN → IDLE only at the last clock of a frame (h=H_TOTAL-1, v=V_TOTAL-1) with en=0. Deasserting en mid-frame always completes the frame.
- Active pixel: state RUN, h_cnt<H_ACTIVE, v_cnt<V_ACTIVE. Exactly H_ACTIVE×V_ACTIVE read strobes per frame.
- In IDLE: rd_en_out=0, de_out=0, pix_out=0, syncs at inactive level (~SYNC_POL). The alignment pipeline still drains normally.
- pix_out equals data_in when the delayed active flag is set, otherwise 0.
- Reset (any time, including mid-line): all outputs and state are forced to reset values immediately.
  - After release, scanning restarts at (0,0) only via IDLE→RUN.

## Timing
- Reset values: rd_en_out=0, de_out=0, pix_out=0, frame_start=0, hsync_out=vsync_out=~SYNC_POL, state IDLE, counters 0.
- en sampled high at edge k → RUN from edge k, counter (0,0) during cycle k..k+1.
- rd_en_out is registered: high from edge k+1 for the (0,0) pixel. In general, rd_en_out lags the counter by 1 clock.
- Frame buffer data is valid RD_LAT clocks after rd_en_out is sampled.
- pix_out, de_out, hsync_out, vsync_out and frame_start are registered and mutually aligned.
  - They lag rd_en_out by RD_LAT+1 clocks, i.e. RD_LAT+2 clocks from the counter.
  - Default total latency is 3 clocks.
- Back-to-back frames with en held high have no gap: V_TOTAL×H_TOTAL clocks per frame.

## Structure
- Package disp_timing_pkg holds:
  - default timing constants for 640x480@60;
  - H_TOTAL/V_TOTAL derivation functions;
  - the state enum (IDLE, RUN).
- Sub-module disp_delay_line: parameterized depth and width shift register with async active-low reset and per-bit reset value. It delays the active flag, syncs and frame_start by RD_LAT+1 stages.

## Test plan
All scenarios use the small configuration H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), RD_LAT=1. The frame-buffer model returns an incrementing value from 1 per sampled strobe.

1. Hold reset low with en=1 → all outputs at reset values. hsync_out=vsync_out=1 (SYNC_POL=0). No strobes until release.
2. Release reset, en sampled high at edge k → rd_en_out high edges k+1..k+4, low for 4 clocks, repeating. Exactly 12 strobes per frame.
3. Alignment: de_out rises at edge k+3, in the same clock as frame_start. pix_out runs 1,2,3,4 on line 0 and totals 1..12 per frame. pix_out=0 whenever de_out=0.
4. Syncs: hsync_out low for 2 clocks, starting 5 clocks after each de_out rise. vsync_out low for exactly 8 clocks, starting 32 clocks after the first de_out rise of the frame.
5. Drop en mid-line 1 → frame completes with all 12 pixels, then IDLE. Re-assert en → new frame_start and pix_out resumes at 13.
6. Assert reset mid-line 2 → outputs go to reset values without waiting for a clock edge. After release and en, a clean frame starts at (0,0).

Source files
------------

// File: rtl/disp_timing_pkg.sv
// Shared timing constants, total-derivation helpers and scan state type for the
// display timing generator.
package disp_timing_pkg;

    // 640x480@60 defaults
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam logic        DEF_SYNC_POL = 1'b0;
    localparam int unsigned DEF_RD_LAT   = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/disp_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset to a per-bit value.
module disp_delay_line #(
    parameter int unsigned      DEPTH   = 2,
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/disp_timing_gen.sv
// Raster scan-out controller: counters, frame-buffer read strobe and
// sync/data-enable outputs aligned with the returned pixel data.
module disp_timing_gen
    import disp_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = DEF_SYNC_POL,
    parameter int unsigned RD_LAT   = DEF_RD_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        rd_en_out,
    input  logic [23:0] data_in,
    output logic [23:0] pix_out,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    state_t        state, state_nxt;
    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic          frame_end;

    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // IDLE pins the counters at (0,0) so the first RUN cycle scans pixel (0,0)
    always_comb begin
        state_nxt = state;
        h_nxt     = '0;
        v_nxt     = '0;
        case (state)
            IDLE: begin
                if (en) state_nxt = RUN;
            end
            RUN: begin
                if (frame_end && !en) state_nxt = IDLE;
                if (h_cnt != H_LAST) begin
                    h_nxt = h_cnt + 1'b1;
                    v_nxt = v_cnt;
                end else begin
                    h_nxt = '0;
                    v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic [31:0] h_pos, v_pos;
    logic        running, active, hs_region, vs_region;
    logic        hs_raw, vs_raw, fs_raw;

    assign h_pos     = 32'(h_cnt);
    assign v_pos     = 32'(v_cnt);
    assign running   = (state == RUN);
    assign active    = running && (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
    assign hs_region = running && (h_pos >= H_ACTIVE + H_FP) && (h_pos < H_ACTIVE + H_FP + H_SYNC);
    assign vs_region = running && (v_pos >= V_ACTIVE + V_FP) && (v_pos < V_ACTIVE + V_FP + V_SYNC);
    assign hs_raw    = hs_region ? SYNC_POL : ~SYNC_POL;
    assign vs_raw    = vs_region ? SYNC_POL : ~SYNC_POL;
    assign fs_raw    = active && (h_cnt == '0) && (v_cnt == '0);

    // Timing flags travel RD_LAT+1 stages so they meet data_in at the output register
    logic [3:0] dl_q;
    logic       act_d, hs_d, vs_d, fs_d;

    disp_delay_line #(
        .DEPTH   (RD_LAT + 1),
        .WIDTH   (4),
        .RST_VAL ({1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0})
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .d     ({active, hs_raw, vs_raw, fs_raw}),
        .q     (dl_q)
    );

    assign {act_d, hs_d, vs_d, fs_d} = dl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en_out   <= 1'b0;
            de_out      <= 1'b0;
            pix_out     <= '0;
            hsync_out   <= ~SYNC_POL;
            vsync_out   <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            rd_en_out   <= active;
            de_out      <= act_d;
            pix_out     <= act_d ? data_in : '0;
            hsync_out   <= hs_d;
            vsync_out   <= vs_d;
            frame_start <= fs_d;
        end
    end

endmodule
